f2_cmd_sched: RTL and testbench

F2_CMD_SCHED -- requirements
Module: f2_cmd_sched

---
 rtl/f2_pkg.sv | 29 ++
 rtl/f2_cmd_sched_if.sv | 22 ++
 rtl/f2_cmd_fifo.sv | 57 +++++
 rtl/f2_cmd_sched.sv | 126 ++++++++++++
 tb/tb_f2_cmd_sched.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/f2_pkg.sv
// Shared types for the F2 command scheduler: key codes,
// scheduler states and default queue depth.
package f2_pkg;

  typedef enum logic [2:0] {
    NONE  = 3'd0,
    FWD   = 3'd1,
    BACK  = 3'd2,
    ROT_R = 3'd3,
    NAV   = 3'd4
  } instr_e;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } state_e;

  localparam int FIFO_DEPTH_DEF = 4;

  function automatic logic is_key(logic [2:0] c);
    return c inside {FWD, BACK, ROT_R, NAV};
  endfunction

  function automatic logic is_rep(logic [2:0] c);
    return c inside {FWD, BACK};
  endfunction

endpackage

// File: rtl/f2_cmd_sched_if.sv
// GPU command handshake: scheduler presents a command,
// GPU accepts it and later pulses done.
interface f2_cmd_sched_if;
  logic       cmd_valid;
  logic [2:0] cmd_instr;
  logic       gpu_ready;
  logic       gpu_done;

  modport master (
    output cmd_valid,
    output cmd_instr,
    input  gpu_ready,
    input  gpu_done
  );

  modport slave (
    input  cmd_valid,
    input  cmd_instr,
    output gpu_ready,
    output gpu_done
  );
endinterface

// File: rtl/f2_cmd_fifo.sv
// Circular command queue; a push on a full queue is taken
// only when a pop happens on the same edge.
module f2_cmd_fifo
  import f2_pkg::*;
#(
  parameter  int DEPTH = FIFO_DEPTH_DEF,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          sysclk,
  input  logic          reset,
  input  logic          push,
  input  logic [2:0]    din,
  input  logic          pop,
  output logic [2:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [2:0]    mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] nxt(logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rp];

  always_ff @(posedge sysclk) begin
    if (do_push) mem[wp] <= din;
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= nxt(wp);
      if (do_pop)  rp <= nxt(rp);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/f2_cmd_sched.sv
// Key-event edge detect, move auto-repeat, command queue
// and GPU issue FSM.
module f2_cmd_sched
  import f2_pkg::*;
#(
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000,
  parameter int FIFO_DEPTH    = FIFO_DEPTH_DEF
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       write,
  input  logic [2:0] instruction,
  f2_cmd_sched_if.master gpu,
  output logic       busy,
  output logic [2:0] fifo_count,
  output logic       overflow
);

  localparam int MAXC =
    (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW  = $clog2(MAXC + 1);
  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] CMAX = '1;
  localparam logic [CW-1:0] DLY  = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] PER  = CW'(REPEAT_PERIOD);

  logic           prev_wr;
  logic [2:0]     prev_in;
  logic [CW-1:0]  hold_cnt;
  logic [CW-1:0]  cnt_inc;
  logic [CW-1:0]  target;
  logic           rep_ph;
  logic           vkey;
  logic           key_ev;
  logic           held;
  logic           rpt_ev;
  logic           ev;
  state_e         st;
  state_e         st_nxt;
  logic           pop;
  logic           full;
  logic           empty;
  logic [2:0]     head;
  logic [2:0]     instr_q;
  logic [FCW-1:0] fcnt;

  assign vkey    = write && is_key(instruction);
  assign key_ev  = vkey && (!prev_wr || instruction != prev_in);
  assign held    = vkey && prev_wr && instruction == prev_in;
  assign cnt_inc = (hold_cnt == CMAX) ? hold_cnt
                                      : hold_cnt + CW'(1);
  // after the first repeat the counter restarts toward the period
  assign target  = rep_ph ? PER : DLY;
  assign rpt_ev  = held && is_rep(instruction) && cnt_inc == target;
  assign ev      = key_ev || rpt_ev;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      prev_wr  <= 1'b0;
      prev_in  <= '0;
      hold_cnt <= '0;
      rep_ph   <= 1'b0;
    end else begin
      prev_wr <= write;
      prev_in <= instruction;
      if (held && rpt_ev) begin
        hold_cnt <= '0;
        rep_ph   <= 1'b1;
      end else if (held) begin
        hold_cnt <= cnt_inc;
      end else begin
        hold_cnt <= '0;
        rep_ph   <= 1'b0;
      end
    end
  end

  f2_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sysclk (sysclk),
    .reset  (reset),
    .push   (ev),
    .din    (instruction),
    .pop    (pop),
    .dout   (head),
    .full   (full),
    .empty  (empty),
    .count  (fcnt)
  );

  always_ff @(posedge sysclk) begin
    if (reset) begin
      st       <= IDLE;
      instr_q  <= '0;
      overflow <= 1'b0;
    end else begin
      st <= st_nxt;
      if (pop) instr_q <= head;
      if (ev && full && !pop) overflow <= 1'b1;
    end
  end

  always_comb begin
    st_nxt = st;
    pop    = 1'b0;
    unique case (st)
      IDLE: begin
        if (!empty) begin
          pop    = 1'b1;
          st_nxt = ISSUE;
        end
      end
      ISSUE:     if (gpu.gpu_ready) st_nxt = WAIT_DONE;
      WAIT_DONE: if (gpu.gpu_done)  st_nxt = IDLE;
      default:   st_nxt = IDLE;
    endcase
  end

  assign gpu.cmd_valid = (st == ISSUE);
  assign gpu.cmd_instr = instr_q;
  assign busy          = (st != IDLE);
  assign fifo_count    = 3'(fcnt);

endmodule

// File: tb/tb_f2_cmd_sched.sv
// Random and directed stimulus against a queue-based
// reference model of the command scheduler.
module tb_f2_cmd_sched;

  localparam int D     = 8;
  localparam int P     = 4;
  localparam int DEPTH = 4;

  logic       sysclk = 1'b0;
  logic       reset;
  logic       write;
  logic [2:0] instruction;
  logic       busy;
  logic [2:0] fifo_count;
  logic       overflow;

  f2_cmd_sched_if gif ();

  f2_cmd_sched #(
    .REPEAT_DELAY  (D),
    .REPEAT_PERIOD (P),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .sysclk      (sysclk),
    .reset       (reset),
    .write       (write),
    .instruction (instruction),
    .gpu         (gif),
    .busy        (busy),
    .fifo_count  (fifo_count),
    .overflow    (overflow)
  );

  always #5 sysclk = ~sysclk;

  int n_cmp = 0;
  int n_bad = 0;

  // model: 0 idle, 1 issued, 2 waiting for done
  int         m_mode;
  logic [2:0] m_cur;
  int         q[$];
  bit         m_ovf;
  bit         m_pw;
  logic [2:0] m_pi;
  int         m_n;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model(input bit w, input logic [2:0] c,
                       input bit r, input bit d, input bit rs);
    bit vk, key, hld, ev, popd;
    int pre;
    if (rs) begin
      m_mode = 0; m_cur = 0; q.delete(); m_ovf = 0;
      m_pw = 0; m_pi = 0; m_n = 0;
      return;
    end
    vk  = w && c >= 1 && c <= 4;
    key = vk && (!m_pw || c != m_pi);
    hld = vk && m_pw && c == m_pi;
    if (key) m_n = 0;
    else if (hld) m_n++;
    else m_n = 0;
    ev = key || (hld && (c == 1 || c == 2) && m_n >= D
                 && ((m_n - D) % P) == 0);
    pre  = q.size();
    popd = 0;
    case (m_mode)
      0: if (pre > 0) begin
           m_cur = 3'(q.pop_front()); m_mode = 1; popd = 1;
         end
      1: if (r) m_mode = 2;
      default: if (d) m_mode = 0;
    endcase
    if (ev) begin
      if (pre < DEPTH || popd) q.push_back(int'(c));
      else m_ovf = 1;
    end
    m_pw = w;
    m_pi = c;
  endtask

  task automatic step(input bit w, input logic [2:0] c,
                      input bit r, input bit d, input bit rs);
    write = w; instruction = c;
    gif.gpu_ready = r; gif.gpu_done = d; reset = rs;
    @(posedge sysclk);
    model(w, c, r, d, rs);
    #1;
    chk("cmd_valid", 32'(gif.cmd_valid), 32'(m_mode == 1));
    chk("cmd_instr", 32'(gif.cmd_instr), 32'(m_cur));
    chk("busy", 32'(busy), 32'(m_mode != 0));
    chk("fifo_count", 32'(fifo_count), 32'(q.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  initial begin
    bit w, r, d, rs;
    logic [2:0] c;
    logic [2:0] seq5 [6];
    seq5 = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd1, 3'd2};

    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // single rotate held, GPU ready
    for (int k = 0; k < 10; k++) step(1, 3, 1, 0, 0);
    for (int k = 0; k < 4; k++) step(0, 0, 1, k == 1, 0);

    // forward held with GPU stalled: auto-repeats
    step(0, 0, 0, 0, 1);
    for (int k = 0; k < 20; k++) step(1, 1, 0, 0, 0);

    // distinct events until the queue overflows
    step(0, 0, 0, 0, 1);
    foreach (seq5[k]) step(1, seq5[k], 0, 0, 0);
    chk("ovf_full", 32'(overflow), 32'd1);
    chk("cnt_full", 32'(fifo_count), 32'd4);

    // stall in ISSUE with an early done, then accept and finish
    for (int k = 0; k < 5; k++) step(0, 0, 0, k == 2, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);

    // reset while waiting for done with entries queued
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1);
    chk("rst_valid", 32'(gif.cmd_valid), 32'd0);
    chk("rst_cnt", 32'(fifo_count), 32'd0);

    // code change while held, then held through reset release
    for (int k = 0; k < 6; k++) step(1, 1, 1, 1, 0);
    for (int k = 0; k < 12; k++) step(1, 2, 1, 1, 0);
    step(1, 2, 1, 1, 1);
    for (int k = 0; k < 4; k++) step(1, 2, 1, 1, 0);

    w = 0; c = 0;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 99) >= 92) begin
        w = $urandom_range(0, 3) != 0;
        c = ($urandom_range(0, 9) > 7) ? 3'($urandom_range(0, 7))
                                       : 3'($urandom_range(1, 4));
      end
      r  = $urandom_range(0, 3) == 0;
      d  = $urandom_range(0, 2) == 0;
      rs = $urandom_range(0, 299) == 0;
      step(w, c, r, d, rs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
